mult16_mac: RTL
===============

// Module: mult16_mac
// PURPOSE
//  Multiply-accumulate stage directly downstream of the 16x16 unsigned shift-add multiplier
//  (MULT16, combinational, 32-bit product). Accepts a stream of operand pairs grouped into
//  vectors by in_last, registers operands, instantiates MULT16, and accumulates products.
//  Emits one dot-product result per vector over a valid/ready handshake.
// PARAMETERS
//  ACC_W  40  accumulator/result width, >= 32; sum wraps modulo 2^ACC_W
//  CNT_W  16  beat-counter width; count saturates at all-ones
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      stage can accept a beat this cycle
//  in_a       in   16     unsigned operand A
//  in_b       in   16     unsigned operand B
//  in_last    in   1      beat is the final beat of its vector
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_acc    out  ACC_W  sum of A*B over the vector, mod 2^ACC_W
//  out_count  out  CNT_W  beats in the vector (saturating)
//  out_ovf    out  1      an accumulate carried out of ACC_W during this vector
// BEHAVIOUR
//  - Reset: all pipeline valids, acc, count, ovf, out_valid, out_acc, out_count, out_ovf = 0.
//    Reset mid-vector discards the partial vector and any in-flight beats; no output results.
//  - Beat accepted when in_valid && in_ready. Pipeline: S1 operand regs (a,b,last,v);
//    S2 product reg <= MULT16(S1.a,S1.b); S3 accumulate into acc/count/ovf.
//  - Latency: beat accepted in cycle t with in_last=1 -> out_valid high from cycle t+3.
//  - S3 on valid beat: first beat of a vector loads acc=prod, count=1, ovf=0;
//    later beats acc+=prod (carry out of ACC_W sets ovf sticky), count+=1 saturating.
//  - On last beat: out_acc/out_count/out_ovf <= final values, out_valid <= 1; acc state
//    returns to "first beat" for the next vector (no bubble between vectors).
//  - out_valid && !out_ready: result regs held stable. Result drops after the cycle with
//    out_valid && out_ready unless a new last beat completes that same cycle (then reload).
//  - stall = out_valid && !out_ready && S2.v && S2.last. On stall S1, S2, S3 all freeze and
//    in_ready = 0. in_ready = !stall (combinational from out_ready; documented, intended).
//  - Non-last beats never stall; bubbles (in_valid=0) pass as S*.v=0 and do not touch acc.
//  - Single-beat vector (first and last) is legal: result = A*B, count=1.
//  - Products are unsigned 32-bit zero-extended to ACC_W; no signed mode.
// STRUCTURE
//  - Shared package/include mult_pkg: OP_W=16, PROD_W=32, default ACC_W/CNT_W constants.
//  - One sub-module instance: existing MULT16 between S1 and S2; everything else local.
//  - State per stage: valid, last; S3 holds acc, count, ovf, first-beat flag.
// TESTING
//  - Single beat A=3,B=5,last, out_ready=1 -> cycle t+3: out_acc=15, count=1, ovf=0.
//  - Back-to-back (1,1)(2,2)(3,3)(4,4 last) -> out_acc=30, count=4; in_ready stays 1.
//  - 256 beats 0xFFFF*0xFFFF -> out_acc=0xFFFE000100, ovf=0; 257 beats ->
//    out_acc=0x00FDFE0101, ovf=1.
//  - Two single-beat vectors (2*3),(4*5), out_ready=0 for 6 cycles -> 6 held stable,
//    in_ready=0 while 2nd last waits in S2; after release 6 then 20, none lost/duplicated.
//  - Reset pulse after 2 beats of a 4-beat vector -> all outputs 0; next vector (2*7 last)
//    -> out_acc=14, count=1, no stale contribution.
//  - Random in_valid bubbles and out_ready toggling vs. reference model: every vector
//    result matches sum mod 2^ACC_W, count and ovf; order preserved.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths and defaults for the 16x16 multiplier and the
//               multiply-accumulate stage built on it.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Operand and full-product widths of the 16x16 unsigned multiplier
  localparam int OP_W        = 16;
  localparam int PROD_W      = 32;

  // Default accumulator and beat-counter widths for the MAC stage
  localparam int ACC_W_DEF   = 40;
  localparam int CNT_W_DEF   = 16;

  // Per-stage control carried alongside the data in the MAC pipeline
  typedef struct packed {
    logic v;
    logic last;
  } stage_ctl_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult16.sv
`default_nettype none
// ============================================================================
// Module      : mult16
// Description : Combinational 16x16 unsigned shift-add multiplier producing a
//               full 32-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module mult16
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_prod
);

  // One shifted copy of A per bit of B, gated by that bit
  logic [PROD_W-1:0] w_pp [OP_W];

  for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
    assign w_pp[gi] = i_b[gi] ? (PROD_W'(i_a) << gi) : '0;
  end

  // Sum the partial products
  always_comb begin
    o_prod = '0;
    for (int i = 0; i < OP_W; i++) begin
      o_prod = o_prod + w_pp[i];
    end
  end

endmodule : mult16
`default_nettype wire

// File: rtl/mult16_mac.sv
`default_nettype none
// ============================================================================
// Module      : mult16_mac
// Description : Three-stage multiply-accumulate. Operand beats grouped into
//               vectors by in_last are multiplied and summed; one dot-product
//               result per vector is offered on a valid/ready output.
//               S1 operand regs -> mult16 -> S2 product reg -> S3 accumulate.
// Revision    : 1.0 - initial release
// ============================================================================
module mult16_mac
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Pipeline state
  stage_ctl_t          r_s1;
  logic [OP_W-1:0]     r_s1_a;
  logic [OP_W-1:0]     r_s1_b;
  stage_ctl_t          r_s2;
  logic [PROD_W-1:0]   r_s2_prod;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_first;

  logic [PROD_W-1:0]   w_prod;
  logic                w_stall;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_acc_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_ovf_next;
  logic                w_s3_fire;

  // A finished vector sitting in S2 while the previous result is unconsumed
  // blocks the whole pipe; in_ready therefore follows out_ready combinationally.
  assign w_stall   = out_valid && !out_ready && r_s2.v && r_s2.last;
  assign in_ready  = !w_stall;
  assign w_s3_fire = !w_stall && r_s2.v;

  mult16 u_mult16 (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_prod (w_prod)
  );

  // S1: capture operand beats; a bubble just clears the valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= '0;
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else if (!w_stall) begin
      r_s1.v    <= in_valid;
      r_s1.last <= in_last;
      if (in_valid) begin
        r_s1_a <= in_a;
        r_s1_b <= in_b;
      end
    end
  end

  // S2: register the product of the S1 operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2      <= '0;
      r_s2_prod <= '0;
    end else if (!w_stall) begin
      r_s2 <= r_s1;
      if (r_s1.v) begin
        r_s2_prod <= w_prod;
      end
    end
  end

  // S3 next values: first beat of a vector loads, later beats add with sticky carry
  always_comb begin
    w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(r_s2_prod);
    w_acc_next = ACC_W'(r_s2_prod);
    w_cnt_next = c_cnt_one;
    w_ovf_next = 1'b0;
    if (!r_first) begin
      w_acc_next = w_sum[ACC_W-1:0];
      w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + c_cnt_one;
      w_ovf_next = r_ovf | w_sum[ACC_W];
    end
  end

  // S3: running accumulator; a last beat re-arms the first-beat flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_first <= 1'b1;
    end else if (w_s3_fire) begin
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
      r_first <= r_s2.last;
    end
  end

  // Result registers: load on vector completion, hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (w_s3_fire && r_s2.last) begin
      out_valid <= 1'b1;
      out_acc   <= w_acc_next;
      out_count <= w_cnt_next;
      out_ovf   <= w_ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : mult16_mac
`default_nettype wire
